// File: rtl/ghash_accumulator.sv
// GHASH front-end sequencer: folds each block into Y, drives the GF(2^128) multiplier, presents Y as the tag.
// Optional GHASH_LEN_BLOCK_EN: counts AAD/text blocks and issues the length block internally after the last block.
module ghash_accumulator #(
  parameter int unsigned NB_DATA      = 128,
  parameter int unsigned MULT_LATENCY = 129,
  parameter int unsigned NB_LAT_CNT   = 8
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_hash_key,
  input  logic               i_key_load,
  input  logic [NB_DATA-1:0] i_data,
  input  logic               i_valid,
  input  logic               i_first,
  input  logic               i_last,
`ifdef GHASH_LEN_BLOCK_EN
  input  logic               i_is_aad,
`endif
  output logic               o_ready,
  output logic [NB_DATA-1:0] o_mult_x,
  output logic [NB_DATA-1:0] o_mult_y,
  output logic               o_mult_valid,
  input  logic [NB_DATA-1:0] i_mult_z,
  output logic [NB_DATA-1:0] o_tag,
  output logic               o_tag_valid
);

  localparam logic [NB_LAT_CNT-1:0] LAT_LAST = NB_LAT_CNT'(MULT_LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_LEN  = 2'd2
  } state_t;

  state_t                state;
  logic [NB_DATA-1:0]    h_q;
  logic [NB_DATA-1:0]    x_q;
  logic [NB_DATA-1:0]    y_q;
  logic [NB_DATA-1:0]    tag_q;
  logic [NB_LAT_CNT-1:0] lat_cnt;
  logic                  last_q;
  logic                  ready_q;
  logic                  mult_valid_q;
  logic                  tag_valid_q;

`ifdef GHASH_LEN_BLOCK_EN
  localparam int unsigned NB_BLK_CNT = 64;

  logic [NB_BLK_CNT-1:0] aad_cnt;
  logic [NB_BLK_CNT-1:0] txt_cnt;
  logic                  len_done;
  logic [127:0]          len_block;

  // Bit lengths of AAD and text, 128 bits per block
  assign len_block = {64'(aad_cnt * 64'd128), 64'(txt_cnt * 64'd128)};
`endif

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state        <= ST_IDLE;
      h_q          <= '0;
      x_q          <= '0;
      y_q          <= '0;
      tag_q        <= '0;
      lat_cnt      <= '0;
      last_q       <= 1'b0;
      ready_q      <= 1'b1;
      mult_valid_q <= 1'b0;
      tag_valid_q  <= 1'b0;
`ifdef GHASH_LEN_BLOCK_EN
      aad_cnt      <= '0;
      txt_cnt      <= '0;
      len_done     <= 1'b0;
`endif
    end else begin
      tag_valid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_key_load) h_q <= i_hash_key;
          if (i_valid && ready_q) begin
            x_q          <= (i_first ? '0 : y_q) ^ i_data;
            last_q       <= i_last;
            lat_cnt      <= '0;
            ready_q      <= 1'b0;
            mult_valid_q <= 1'b1;
            state        <= ST_MULT;
`ifdef GHASH_LEN_BLOCK_EN
            if (i_first) begin
              aad_cnt <= i_is_aad ? NB_BLK_CNT'(1) : '0;
              txt_cnt <= i_is_aad ? '0 : NB_BLK_CNT'(1);
            end else if (i_is_aad) begin
              aad_cnt <= aad_cnt + NB_BLK_CNT'(1);
            end else begin
              txt_cnt <= txt_cnt + NB_BLK_CNT'(1);
            end
`endif
          end
        end

        // Operands stay frozen; the multiplier reads x at every stage
        ST_MULT: begin
          if (lat_cnt == LAT_LAST) begin
            y_q          <= i_mult_z;
            mult_valid_q <= 1'b0;
`ifdef GHASH_LEN_BLOCK_EN
            if (last_q && !len_done) begin
              state <= ST_LEN;
            end else begin
              state    <= ST_IDLE;
              ready_q  <= 1'b1;
              len_done <= 1'b0;
              if (last_q) begin
                tag_q       <= i_mult_z;
                tag_valid_q <= 1'b1;
              end
            end
`else
            state   <= ST_IDLE;
            ready_q <= 1'b1;
            if (last_q) begin
              tag_q       <= i_mult_z;
              tag_valid_q <= 1'b1;
            end
`endif
          end else begin
            lat_cnt <= lat_cnt + NB_LAT_CNT'(1);
          end
        end

`ifdef GHASH_LEN_BLOCK_EN
        // Internally issued length block, always the final multiply of the message
        ST_LEN: begin
          x_q          <= y_q ^ NB_DATA'(len_block);
          lat_cnt      <= '0;
          len_done     <= 1'b1;
          mult_valid_q <= 1'b1;
          state        <= ST_MULT;
        end
`endif

        default: begin
          state        <= ST_IDLE;
          ready_q      <= 1'b1;
          mult_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready      = ready_q;
  assign o_mult_x     = h_q;
  assign o_mult_y     = x_q;
  assign o_mult_valid = mult_valid_q;
  assign o_tag        = tag_q;
  assign o_tag_valid  = tag_valid_q;

endmodule

// File: tb/tb_ghash_accumulator.sv
// Directed bench for ghash_accumulator with a behavioural GF(2^128) multiplier of fixed latency.
module tb_ghash_accumulator;

  localparam int unsigned NB  = 128;
  localparam int unsigned LAT = 129;

  localparam logic [NB-1:0] H_ID = 128'h80000000000000000000000000000000;
  localparam logic [NB-1:0] BLK_A = 128'h0123456789abcdef0123456789abcdef;
  localparam logic [NB-1:0] BLK_B = 128'hffffffffffffffff0000000000000000;
  localparam logic [NB-1:0] BLK_D = 128'h11111111222222223333333344444444;
  localparam logic [NB-1:0] BLK_E = 128'h000000000000000000000000ffffffff;
  localparam logic [NB-1:0] BLK_G = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  localparam logic [NB-1:0] BLK_R = 128'h00000000000000000000000000000001;
  localparam logic [NB-1:0] GCM_H = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [NB-1:0] GCM_C = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam logic [NB-1:0] GCM_L = 128'h00000000000000000000000000000080;
  localparam logic [NB-1:0] GCM_GHASH = 128'hf38cbb1ad69223dcc3457ae5b6b0f885;

`ifdef GHASH_LEN_BLOCK_EN
  localparam logic [NB-1:0] EXP_T1 = 128'hfedcba98765432100123456789abccef;
  localparam logic [NB-1:0] EXP_T4 = 128'h111111112222222233333333bbbbbabb;
  localparam logic [NB-1:0] EXP_T5 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e170;
  localparam int            EXP_DLY = 3 * LAT + 2;
  localparam int            EXP_LAST_LOW = 2 * LAT + 1;
`else
  localparam logic [NB-1:0] EXP_T1 = 128'hfedcba98765432100123456789abcdef;
  localparam logic [NB-1:0] EXP_T4 = 128'h111111112222222233333333bbbbbbbb;
  localparam logic [NB-1:0] EXP_T5 = BLK_G;
  localparam int            EXP_DLY = 2 * LAT + 1;
  localparam int            EXP_LAST_LOW = LAT;
`endif

  logic          clk;
  logic          rst;
  logic [NB-1:0] hash_key;
  logic          key_load;
  logic [NB-1:0] data;
  logic          valid;
  logic          first;
  logic          last;
`ifdef GHASH_LEN_BLOCK_EN
  logic          is_aad;
`endif
  logic          ready;
  logic [NB-1:0] mult_x;
  logic [NB-1:0] mult_y;
  logic          mult_valid;
  logic [NB-1:0] mult_z;
  logic [NB-1:0] tag;
  logic          tag_valid;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int mv_cnt = 0;

  ghash_accumulator #(.NB_DATA(NB), .MULT_LATENCY(LAT), .NB_LAT_CNT(8)) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_hash_key   (hash_key),
    .i_key_load   (key_load),
    .i_data       (data),
    .i_valid      (valid),
    .i_first      (first),
    .i_last       (last),
`ifdef GHASH_LEN_BLOCK_EN
    .i_is_aad     (is_aad),
`endif
    .o_ready      (ready),
    .o_mult_x     (mult_x),
    .o_mult_y     (mult_y),
    .o_mult_valid (mult_valid),
    .i_mult_z     (mult_z),
    .o_tag        (tag),
    .o_tag_valid  (tag_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // GCM bit-reflected multiply: bit 127 is the coefficient of x^0
  function automatic logic [NB-1:0] gf_mul(input logic [NB-1:0] a, input logic [NB-1:0] b);
    logic [NB-1:0] z;
    logic [NB-1:0] v;
    z = '0;
    v = b;
    for (int i = NB - 1; i >= 0; i--) begin
      if (a[i]) z = z ^ v;
      v = v[0] ? ((v >> 1) ^ {8'he1, 120'h0}) : (v >> 1);
    end
    return z;
  endfunction

  // Product is only valid in the LAT-th consecutive enabled cycle; garbage otherwise
  always @(posedge clk or posedge rst) begin
    if (rst) mv_cnt <= 0;
    else     mv_cnt <= mult_valid ? mv_cnt + 1 : 0;
  end

  always_comb begin
    mult_z = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
    if (mult_valid && mv_cnt == LAT - 1) mult_z = gf_mul(mult_x, mult_y);
  end

  task automatic check(input string name, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", name, obs, exp);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!ready) check("ready_timeout", NB'(ready), NB'(1));
  endtask

  task automatic load_key(input logic [NB-1:0] h);
    wait_ready();
    hash_key = h;
    key_load = 1'b1;
    @(negedge clk);
    key_load = 1'b0;
  endtask

  task automatic send(input logic [NB-1:0] blk, input logic f, input logic l);
    wait_ready();
    data  = blk;
    first = f;
    last  = l;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    first = 1'b0;
    last  = 1'b0;
  endtask

  task automatic count_low(output int n);
    n = 0;
    while (!ready && n < 1000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_tag(output int t);
    int n = 0;
    while (!tag_valid && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!tag_valid) check("tag_timeout", NB'(tag_valid), NB'(1));
    t = cyc;
  endtask

  initial begin
    int t0;
    int t1;
    int n;
    logic seen;
    rst      = 1'b1;
    hash_key = '0;
    key_load = 1'b0;
    data     = '0;
    valid    = 1'b0;
    first    = 1'b0;
    last     = 1'b0;
`ifdef GHASH_LEN_BLOCK_EN
    is_aad   = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", NB'(ready), NB'(1));
    check("rst_mult_valid", NB'(mult_valid), NB'(0));
    check("rst_tag_valid", NB'(tag_valid), NB'(0));
    check("rst_tag", tag, '0);
    check("rst_mult_x", mult_x, '0);
    check("rst_mult_y", mult_y, '0);

    // Identity key loaded in the same cycle as the first block
    hash_key = H_ID;
    key_load = 1'b1;
    data     = BLK_A;
    first    = 1'b1;
    valid    = 1'b1;
    @(negedge clk);
    key_load = 1'b0;
    valid    = 1'b0;
    first    = 1'b0;
    t0 = cyc;
    check("t1_busy_ready", NB'(ready), NB'(0));
    check("t1_busy_mult_valid", NB'(mult_valid), NB'(1));
    check("t1_mult_x_new_key", mult_x, H_ID);
    check("t1_mult_y", mult_y, BLK_A);
    send(BLK_B, 1'b0, 1'b1);
    wait_tag(t1);
    // Tag-valid cycle sits 2*(LAT+1) cycles after the accept cycle, i.e. 2*LAT+1 edges later
    check("t1_tag_delay", NB'(t1 - t0), NB'(EXP_DLY));
    check("t1_tag", tag, EXP_T1);
    @(negedge clk);
    check("t1_pulse_width", NB'(tag_valid), NB'(0));
    check("t1_tag_hold", tag, EXP_T1);

    // Zero key: tag collapses to zero, ready low LAT cycles per block
    load_key('0);
    send(BLK_D, 1'b1, 1'b0);
    count_low(n);
    check("t2_low_blk0", NB'(n), NB'(LAT));
    send(BLK_E, 1'b0, 1'b0);
    count_low(n);
    check("t2_low_blk1", NB'(n), NB'(LAT));
    send(BLK_G, 1'b0, 1'b1);
    count_low(n);
    check("t2_low_blk2", NB'(n), NB'(EXP_LAST_LOW));
    wait_tag(t1);
    check("t2_tag_zero", tag, '0);

    // GCM Test Case 2
    load_key(GCM_H);
`ifdef GHASH_LEN_BLOCK_EN
    send(GCM_C, 1'b1, 1'b1);
`else
    send(GCM_C, 1'b1, 1'b0);
    send(GCM_L, 1'b0, 1'b1);
`endif
    wait_tag(t1);
    check("t3_gcm_tc2", tag, GCM_GHASH);

    // Block and key load presented while busy must wait / be ignored
    load_key(H_ID);
    send(BLK_D, 1'b1, 1'b0);
    data     = BLK_E;
    last     = 1'b1;
    valid    = 1'b1;
    hash_key = '0;
    key_load = 1'b1;
    n = 0;
    while (!ready && n < 1000) begin
      n++;
      @(negedge clk);
      key_load = 1'b0;
    end
    check("t4_low_while_held", NB'(n), NB'(LAT));
    check("t4_key_unchanged", mult_x, H_ID);
    check("t4_y_unchanged", mult_y, BLK_D);
    @(negedge clk);
    valid = 1'b0;
    last  = 1'b0;
    check("t4_taken_ready", NB'(ready), NB'(0));
    check("t4_taken_y", mult_y, BLK_D ^ BLK_E);
    wait_tag(t1);
    check("t4_tag", tag, EXP_T4);

    // Reset in the middle of a multiply
    send(BLK_G, 1'b1, 1'b1);
    repeat (40) @(negedge clk);
    rst = 1'b1;
    #1;
    check("t5_rst_ready", NB'(ready), NB'(1));
    check("t5_rst_mult_valid", NB'(mult_valid), NB'(0));
    check("t5_rst_tag_valid", NB'(tag_valid), NB'(0));
    check("t5_rst_tag", tag, '0);
    check("t5_rst_mult_x", mult_x, '0);
    check("t5_rst_mult_y", mult_y, '0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (tag_valid) seen = 1'b1;
    end
    check("t5_no_tag_after_abort", NB'(seen), NB'(0));
    load_key(H_ID);
    send(BLK_G, 1'b1, 1'b1);
    wait_tag(t1);
    check("t5_single_block", tag, EXP_T5);

`ifdef GHASH_LEN_BLOCK_EN
    // One AAD block plus two text blocks, length block added internally
    load_key(H_ID);
    is_aad = 1'b1;
    send(BLK_A, 1'b1, 1'b0);
    is_aad = 1'b0;
    send(BLK_B, 1'b0, 1'b0);
    send(BLK_R, 1'b0, 1'b1);
    wait_tag(t1);
    check("t6_len_tag", tag, 128'hfedcba98765432900123456789abccee);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ghash_accumulator.md
Name: ghash_accumulator

Overview:
- Front-end sequencer for the GHASH datapath. Accepts a stream of 128-bit message blocks and forms X_i = Y_{i-1} ^ block_i.
- Drives the 128-stage GF(2^128) multiplier with x = H and y = X_i, waits its fixed latency, and captures Z as the new Y_i.
- After the last block it presents Y as the GHASH tag.
- Sits between the block-formatting logic (upstream) and the GF(2^128) multiplier (downstream).

Parameters:
- NB_DATA, 128: block/field width; any other value is a bad configuration.
- MULT_LATENCY, 129: cycles from the issue cycle to the cycle the multiplier's o_data_z is valid; the multiplier enable is held high throughout.
- NB_LAT_CNT, 8: width of the latency counter; must satisfy 2^NB_LAT_CNT > MULT_LATENCY.

Ports:
- i_clock  in  1  clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_hash_key  in  NB_DATA  hash subkey H.
- i_key_load  in  1  loads H; honoured only in IDLE, ignored otherwise.
- i_data  in  NB_DATA  message block (AAD, ciphertext or length block).
- i_valid  in  1  i_data valid.
- i_first  in  1  qualifies i_valid: first block of a message; Y is treated as 0.
- i_last  in  1  qualifies i_valid: last block of a message.
- o_ready  out  1  block can be accepted this cycle.
- o_mult_x  out  NB_DATA  multiplier x operand = H register.
- o_mult_y  out  NB_DATA  multiplier y operand = X register.
- o_mult_valid  out  1  multiplier enable.
- i_mult_z  in  NB_DATA  multiplier product.
- o_tag  out  NB_DATA  GHASH result.
- o_tag_valid  out  1  one-cycle pulse when o_tag is updated.

Behaviour:
- Reset (async, active-high): state=IDLE; H, X, Y, o_tag, latency counter, last flag all 0. Outputs: o_ready=1, o_mult_valid=0, o_tag_valid=0.
- State IDLE:
  - o_ready=1.
  - i_key_load: H<=i_hash_key. If i_key_load and i_valid occur together, the key loads first and the block uses the new H.
  - Accept on i_valid&o_ready:
    - X <= (i_first ? 0 : Y) ^ i_data
    - last flag <= i_last
    - counter <= 0
    - go to MULT.
- State MULT:
  - o_ready=0, o_mult_valid=1.
  - o_mult_x=H and o_mult_y=X are held stable for the whole wait, because the multiplier samples x combinationally at every stage.
  - Counter increments each cycle.
  - When counter == MULT_LATENCY-1: Y <= i_mult_z.
    - If last flag=1: o_tag <= i_mult_z, pulse o_tag_valid, go to IDLE.
    - Otherwise: go to IDLE.
- o_mult_valid is deasserted in IDLE. Multiplier pipeline contents are don't-care between operations.
- Throughput: one block per MULT_LATENCY+1 cycles. The Y feedback dependency forbids overlap.
- i_valid while o_ready=0: the block is not accepted; upstream must hold it.
- i_first&i_last on the same block: single-block message.
- i_first in the middle of a message: discards the running Y and starts a new message.
- o_tag holds its value until the next tag pulse.
- Reset mid-MULT: aborts the operation; no tag is produced.

Optional Feature:
- Macro: GHASH_LEN_BLOCK_EN.
- Defined:
  - Adds input i_is_aad (qualifies i_valid). Two 64-bit block counters, for AAD and for text, are cleared on i_first.
  - On an accepted i_last block, after its MULT completes, the block enters state LEN and internally issues {aad_cnt*128[63:0], txt_cnt*128[63:0]} as one more block, with o_ready=0.
  - The tag is produced after the LEN multiply, so upstream must not send a length block.
- Undefined: no LEN state or counters; upstream supplies the length block as the i_last block.

Test Plan:
- Reset, then H=0x8000...0 (GF identity); blocks A=0x0123...cdef(first), B=0xffff...0000(last) -> o_tag = A^B, o_tag_valid exactly one cycle, 2*(MULT_LATENCY+1) cycles after the first accept.
- H=0, any 3 blocks -> o_tag=0; o_ready low exactly MULT_LATENCY cycles per block.
- GCM spec Test Case 2 (H=66e94bd4ef8a2c3b884cfa59ca342b2e, C=0388dace60b6a392f328c2b971b2fe78, len block 0...0080) -> o_tag equals the published GHASH value.
- i_valid held during MULT, and i_key_load pulsed during MULT -> no extra accept, H unchanged; the block is taken on return to IDLE.
- Reset asserted mid-MULT -> all outputs return to reset values immediately; no o_tag_valid; a following single-block message with H=identity gives o_tag=block.
- GHASH_LEN_BLOCK_EN: H=identity, 1 AAD block (first) + 2 text blocks (last) -> o_tag = XOR of the 3 blocks ^ {64'd128, 64'd256}.
